// File: rtl/led_mode_sequencer.sv
// LED display sequencer: key presses select manual/auto-up/auto-down/running-light
// modes and drive a registered LED value stepped by a programmable tick prescaler.
module led_mode_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int LED_W    = 4
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic [1:0]       Key_Out,
  output logic [LED_W-1:0] LED,
  output logic [1:0]       Mode,
  output logic             Paused
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_UP   = 2'b01,
    AUTO_DOWN = 2'b10,
    RUN       = 2'b11
  } mode_t;

  mode_t            r_mode;
  mode_t            w_mode_nxt;
  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_nxt;
  logic             r_paused;
  logic             w_paused_nxt;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] w_presc_nxt;
  logic [1:0]       r_key_prev;
  logic [1:0]       w_press;
  logic             w_mode_press;
  logic             w_act_press;
  logic             w_counting;
  logic             w_tick;

  // State register; reset samples the keys so a key held through reset is not a press
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      r_mode     <= MANUAL;
      r_led      <= '0;
      r_paused   <= 1'b0;
      r_presc    <= '0;
      r_key_prev <= Key_Out;
    end else begin
      r_mode     <= w_mode_nxt;
      r_led      <= w_led_nxt;
      r_paused   <= w_paused_nxt;
      r_presc    <= w_presc_nxt;
      r_key_prev <= Key_Out;
    end
  end

  // Next-state logic: any key press pre-empts the tick for that cycle
  always_comb begin
    w_press      = Key_Out & ~r_key_prev;
    w_mode_press = w_press[1] & ~w_press[0];
    w_act_press  = w_press[0] & ~w_press[1];
    w_counting   = (r_mode != MANUAL) && !r_paused;
    w_tick       = w_counting && (r_presc == TICK_LAST);

    w_mode_nxt   = r_mode;
    w_led_nxt    = r_led;
    w_paused_nxt = r_paused;
    w_presc_nxt  = r_presc;

    if (w_mode_press) begin
      w_paused_nxt = 1'b0;
      w_presc_nxt  = '0;
      case (r_mode)
        MANUAL:    w_mode_nxt = AUTO_UP;
        AUTO_UP:   w_mode_nxt = AUTO_DOWN;
        AUTO_DOWN: w_mode_nxt = RUN;
        RUN:       w_mode_nxt = MANUAL;
        default:   w_mode_nxt = MANUAL;
      endcase
      if (w_mode_nxt == RUN) begin
        w_led_nxt = LED_W'(1);
      end else begin
        w_led_nxt = r_led;
      end
    end else if (w_act_press) begin
      if (r_mode == MANUAL) begin
        w_led_nxt = r_led + LED_W'(1);
      end else begin
        w_paused_nxt = ~r_paused;
      end
    end else if (w_press != 2'b00) begin
      // Both keys pressed together: ignored entirely
      w_mode_nxt = r_mode;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      case (r_mode)
        AUTO_UP:   w_led_nxt = r_led + LED_W'(1);
        AUTO_DOWN: w_led_nxt = r_led - LED_W'(1);
        RUN:       w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
        default:   w_led_nxt = r_led;
      endcase
    end else if (w_counting) begin
      w_presc_nxt = r_presc + CNT_W'(1);
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    LED    = r_led;
    Mode   = r_mode;
    Paused = r_paused;
  end

endmodule
